// File: rtl/guard_reset_ctrl_pkg.sv
// guard_reset_ctrl_pkg: shared types for the guard reset recovery sequencer.
// Holds the sequencer state encoding, the cause bit positions and a small
// helper that packs the two guard requests into a cause vector.
package guard_reset_ctrl_pkg;

  // Recovery sequence phases, IDLE first so the reset encoding is all-zero.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISOLATE = 3'd1,
    RESET   = 3'd2,
    SETTLE  = 3'd3,
    CLEAR   = 3'd4
  } guard_rst_state_e;

  // Bit positions inside the sticky cause vector.
  localparam int CauseRd = 0;
  localparam int CauseWr = 1;

  // Pack the read/write guard requests into cause-vector layout.
  function automatic logic [1:0] cause_bits(input logic rd, input logic wr);
    logic [1:0] bits;
    bits          = 2'b00;
    bits[CauseRd] = rd;
    bits[CauseWr] = wr;
    return bits;
  endfunction

endpackage

// File: rtl/guard_cycle_counter.sv
// guard_cycle_counter: loadable down-counter with a registered zero flag.
// One instance is time-shared by the drain, reset-hold and settle phases.
// Decrement requests at zero are ignored so the count never wraps.
module guard_cycle_counter #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [Width-1:0] count_r;

  // Load has priority over decrement; the zero flag tracks the new count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {Width{1'b0}};
      zero    <= 1'b1;
    end else if (load) begin
      count_r <= load_value;
      zero    <= (load_value == {Width{1'b0}});
    end else if (dec && !zero) begin
      count_r <= count_r - Width'(1);
      zero    <= (count_r == Width'(1));
    end else begin
      count_r <= count_r;
      zero    <= zero;
    end
  end

endmodule

// File: rtl/guard_reset_ctrl.sv
// guard_reset_ctrl: recovery sequencer shared by the AXI read/write guards.
// On a latched guard request it isolates the guarded port, waits for the
// in-flight handshakes to drain (bounded by DrainTimeout), holds the slave
// in reset, waits a settle time and returns a one-cycle reset_clear_o.
// Optional reset-event counter: define GUARD_RESET_CTRL_EVT_CNT_EN to add
// the evt_cnt_o port and its saturating counter.
module guard_reset_ctrl
  import guard_reset_ctrl_pkg::*;
#(
  parameter int CntWidth     = 8,
  parameter int DrainTimeout = 64,
  parameter int EvtCntWidth  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rd_reset_req_i,
  input  logic                wr_reset_req_i,
  input  logic                inflight_i,
  input  logic [CntWidth-1:0] rst_cycles_i,
  input  logic [CntWidth-1:0] settle_cycles_i,
  input  logic                irq_clear_i,
  output logic                isolate_o,
  output logic                slv_rst_o,
  output logic                reset_clear_o,
  output logic                busy_o,
  output logic [1:0]          cause_o,
  output logic                drain_timeout_o,
  output logic                irq_o
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
  ,
  output logic [EvtCntWidth-1:0] evt_cnt_o
`endif
);

  // The drain budget is loaded as DrainTimeout-1, so it must fit the counter.
  if ((DrainTimeout < 1) || (DrainTimeout > ((2 ** CntWidth) - 1))) begin : g_bad_drain_timeout
    $error("guard_reset_ctrl: DrainTimeout must be in 1 .. 2**CntWidth-1");
  end
  if (EvtCntWidth < 1) begin : g_bad_evt_width
    $error("guard_reset_ctrl: EvtCntWidth must be at least 1");
  end

  guard_rst_state_e    state_r;
  guard_rst_state_e    next_state_s;
  logic                req_s;
  logic [1:0]          new_cause_s;
  logic                start_s;
  logic                timeout_evt_s;
  logic                cnt_load_s;
  logic [CntWidth-1:0] cnt_load_val_s;
  logic                cnt_dec_s;
  logic                cnt_zero_s;
  logic [CntWidth-1:0] rst_len_m1_s;
  logic [CntWidth-1:0] settle_m1_s;

  // Request decode and phase lengths minus one for counter loading.
  always_comb begin
    req_s       = rd_reset_req_i | wr_reset_req_i;
    new_cause_s = cause_bits(rd_reset_req_i, wr_reset_req_i);
    if (rst_cycles_i == CntWidth'(0)) begin
      // A zero hold length still gives the slave one reset cycle.
      rst_len_m1_s = CntWidth'(0);
    end else begin
      rst_len_m1_s = rst_cycles_i - CntWidth'(1);
    end
    if (settle_cycles_i == CntWidth'(0)) begin
      settle_m1_s = CntWidth'(0);
    end else begin
      settle_m1_s = settle_cycles_i - CntWidth'(1);
    end
  end

  // Next-state selection and control of the shared phase counter.
  always_comb begin
    next_state_s   = state_r;
    start_s        = 1'b0;
    timeout_evt_s  = 1'b0;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = CntWidth'(0);
    cnt_dec_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          next_state_s   = ISOLATE;
          start_s        = 1'b1;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = CntWidth'(DrainTimeout - 1);
        end else begin
          next_state_s = IDLE;
        end
      end
      ISOLATE: begin
        if (!inflight_i) begin
          next_state_s   = RESET;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = rst_len_m1_s;
        end else if (cnt_zero_s) begin
          // Drain budget exhausted: proceed anyway and flag it.
          next_state_s   = RESET;
          timeout_evt_s  = 1'b1;
          cnt_load_s     = 1'b1;
          cnt_load_val_s = rst_len_m1_s;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      RESET: begin
        if (cnt_zero_s) begin
          if (settle_cycles_i == CntWidth'(0)) begin
            next_state_s = CLEAR;
          end else begin
            next_state_s   = SETTLE;
            cnt_load_s     = 1'b1;
            cnt_load_val_s = settle_m1_s;
          end
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero_s) begin
          next_state_s = CLEAR;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      CLEAR: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  guard_cycle_counter #(
    .Width(CntWidth)
  ) u_cycle_counter (
    .clk       (clk_i),
    .rst       (rst_i),
    .load      (cnt_load_s),
    .load_value(cnt_load_val_s),
    .dec       (cnt_dec_s),
    .zero      (cnt_zero_s)
  );

  // State register with outputs registered from the next state; sticky
  // status bits let a same-cycle set event win over irq_clear_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r         <= IDLE;
      isolate_o       <= 1'b0;
      slv_rst_o       <= 1'b0;
      reset_clear_o   <= 1'b0;
      busy_o          <= 1'b0;
      cause_o         <= 2'b00;
      drain_timeout_o <= 1'b0;
      irq_o           <= 1'b0;
    end else begin
      state_r         <= next_state_s;
      isolate_o       <= (next_state_s != IDLE);
      slv_rst_o       <= (next_state_s == RESET);
      reset_clear_o   <= (next_state_s == CLEAR);
      busy_o          <= (next_state_s != IDLE);
      cause_o         <= (irq_clear_i ? 2'b00 : cause_o) | new_cause_s;
      drain_timeout_o <= timeout_evt_s | (drain_timeout_o & ~irq_clear_i);
      irq_o           <= start_s | (irq_o & ~irq_clear_i);
    end
  end

`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
  // Count recovery sequence starts, holding at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_cnt_o <= {EvtCntWidth{1'b0}};
    end else if (start_s && (evt_cnt_o != {EvtCntWidth{1'b1}})) begin
      evt_cnt_o <= evt_cnt_o + EvtCntWidth'(1);
    end else begin
      evt_cnt_o <= evt_cnt_o;
    end
  end
`endif

endmodule

// File: tb/tb_guard_reset_ctrl.sv
// tb_guard_reset_ctrl: self-checking bench for guard_reset_ctrl.
// Two instances (DrainTimeout 64 and 4) each get their own guard emulation;
// a phase/elapsed-time reference model predicts every output each cycle.
module tb_guard_reset_ctrl;

  localparam int P_IDLE = 0;
  localparam int P_ISO  = 1;
  localparam int P_RST  = 2;
  localparam int P_SET  = 3;
  localparam int P_CLR  = 4;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rd_req   [2];
  logic       wr_req   [2];
  logic       inflight [2];
  logic [7:0] rst_cycles;
  logic [7:0] settle_cycles;
  logic       irq_clear;
  logic       isolate  [2];
  logic       slv_rst  [2];
  logic       rclr     [2];
  logic       busy     [2];
  logic [1:0] cause    [2];
  logic       dto      [2];
  logic       irq      [2];
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
  logic [7:0] evt      [2];
`endif

  int         dt_of [2] = '{64, 4};
  int         m_phase [2];
  int         m_el [2];
  int         m_rlen [2];
  int         m_slen [2];
  logic [1:0] m_cause [2];
  logic       m_irq [2];
  logic       m_dto [2];
  int         m_evt [2];

  int n_vectors = 0;
  int n_miscompares = 0;

  always #5 clk = ~clk;

  guard_reset_ctrl #(.CntWidth(8), .DrainTimeout(64), .EvtCntWidth(8)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .rd_reset_req_i(rd_req[0]), .wr_reset_req_i(wr_req[0]),
    .inflight_i(inflight[0]), .rst_cycles_i(rst_cycles), .settle_cycles_i(settle_cycles),
    .irq_clear_i(irq_clear), .isolate_o(isolate[0]), .slv_rst_o(slv_rst[0]),
    .reset_clear_o(rclr[0]), .busy_o(busy[0]), .cause_o(cause[0]),
    .drain_timeout_o(dto[0]), .irq_o(irq[0])
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
    , .evt_cnt_o(evt[0])
`endif
  );

  guard_reset_ctrl #(.CntWidth(8), .DrainTimeout(4), .EvtCntWidth(8)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .rd_reset_req_i(rd_req[1]), .wr_reset_req_i(wr_req[1]),
    .inflight_i(inflight[1]), .rst_cycles_i(rst_cycles), .settle_cycles_i(settle_cycles),
    .irq_clear_i(irq_clear), .isolate_o(isolate[1]), .slv_rst_o(slv_rst[1]),
    .reset_clear_o(rclr[1]), .busy_o(busy[1]), .cause_o(cause[1]),
    .drain_timeout_o(dto[1]), .irq_o(irq[1])
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
    , .evt_cnt_o(evt[1])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = P_IDLE; m_el[i] = 0; m_rlen[i] = 1; m_slen[i] = 0;
      m_cause[i] = 2'b00; m_irq[i] = 1'b0; m_dto[i] = 1'b0; m_evt[i] = 0;
    end
  endtask

  // One clock edge of the reference model: phases measured by elapsed cycles.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic req, start, tmo;
      int   hold;
      req   = rd_req[i] | wr_req[i];
      start = 1'b0;
      tmo   = 1'b0;
      hold  = (rst_cycles == 8'd0) ? 1 : int'(rst_cycles);
      case (m_phase[i])
        P_IDLE: if (req) begin m_phase[i] = P_ISO; m_el[i] = 0; start = 1'b1; end
        P_ISO: begin
          if (!inflight[i] || (m_el[i] + 1 == dt_of[i])) begin
            tmo = inflight[i]; m_rlen[i] = hold; m_el[i] = 0; m_phase[i] = P_RST;
          end else m_el[i]++;
        end
        P_RST: begin
          if (m_el[i] + 1 >= m_rlen[i]) begin
            m_el[i] = 0;
            if (settle_cycles == 8'd0) m_phase[i] = P_CLR;
            else begin m_slen[i] = int'(settle_cycles); m_phase[i] = P_SET; end
          end else m_el[i]++;
        end
        P_SET: if (m_el[i] + 1 >= m_slen[i]) m_phase[i] = P_CLR; else m_el[i]++;
        default: m_phase[i] = P_IDLE;
      endcase
      m_cause[i] = (irq_clear ? 2'b00 : m_cause[i]) | {wr_req[i], rd_req[i]};
      m_irq[i]   = start | (m_irq[i] & ~irq_clear);
      m_dto[i]   = tmo | (m_dto[i] & ~irq_clear);
      if (start && m_evt[i] < 255) m_evt[i]++;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("isolate%0d", i), isolate[i], m_phase[i] != P_IDLE);
      check_eq($sformatf("slv_rst%0d", i), slv_rst[i], m_phase[i] == P_RST);
      check_eq($sformatf("reset_clear%0d", i), rclr[i], m_phase[i] == P_CLR);
      check_eq($sformatf("busy%0d", i), busy[i], m_phase[i] != P_IDLE);
      check_eq($sformatf("cause%0d", i), cause[i], m_cause[i]);
      check_eq($sformatf("irq%0d", i), irq[i], m_irq[i]);
      check_eq($sformatf("drain_timeout%0d", i), dto[i], m_dto[i]);
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
      check_eq($sformatf("evt_cnt%0d", i), evt[i], m_evt[i]);
`endif
    end
  endtask

  // Advance one clock, check everything, then let the guards drop on CLEAR.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    for (int i = 0; i < 2; i++) begin
      if (m_phase[i] == P_CLR) begin rd_req[i] = 1'b0; wr_req[i] = 1'b0; end
    end
  endtask

  task automatic pulse_irq_clear();
    irq_clear = 1'b1;
    cycle();
    irq_clear = 1'b0;
  endtask

  // Run one sequence to completion, measuring instance idx from its outputs.
  task automatic run_seq(input int idx, input int drop_at, input int inject_at,
                         output int iso_n, output int srst_n, output int clr_n,
                         output int clr_at, output int first_srst);
    iso_n = 0; srst_n = 0; clr_n = 0; clr_at = -1; first_srst = -1;
    for (int k = 1; k <= 300; k++) begin
      cycle();
      if (isolate[idx]) iso_n++;
      if (slv_rst[idx]) begin srst_n++; if (first_srst < 0) first_srst = k; end
      if (rclr[idx]) begin clr_n++; clr_at = k; end
      if (k == drop_at) inflight[idx] = 1'b0;
      if (k == inject_at) begin
        for (int i = 0; i < 2; i++) if (m_phase[i] == P_RST) wr_req[i] = 1'b1;
      end
      if (k > 1 && m_phase[0] == P_IDLE && m_phase[1] == P_IDLE) break;
      if (k == 300) check_eq("seq_budget", 32'd1, 32'd0);
    end
  endtask

  initial begin
    int iso_n, srst_n, clr_n, clr_at, first_srst;
    rst_i = 1'b1; irq_clear = 1'b0; rst_cycles = 8'd1; settle_cycles = 8'd0;
    for (int i = 0; i < 2; i++) begin rd_req[i] = 1'b0; wr_req[i] = 1'b0; inflight[i] = 1'b0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_i = 1'b0;

    // Single read request, 3-cycle reset, 2-cycle settle.
    rst_cycles = 8'd3; settle_cycles = 8'd2;
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    run_seq(0, 0, 0, iso_n, srst_n, clr_n, clr_at, first_srst);
    check_eq("t1_iso_cycles", iso_n, 7);
    check_eq("t1_srst_cycles", srst_n, 3);
    check_eq("t1_clr_pulses", clr_n, 1);
    check_eq("t1_clr_at", clr_at, 7);
    check_eq("t1_cause", cause[0], 2'b01);
    check_eq("t1_irq", irq[0], 1'b1);
    pulse_irq_clear();

    // Drain wait: inflight high for 5 ISOLATE cycles on the DrainTimeout=64 unit.
    rst_cycles = 8'd1; settle_cycles = 8'd0;
    rd_req[0] = 1'b1; rd_req[1] = 1'b1; inflight[0] = 1'b1;
    run_seq(0, 6, 0, iso_n, srst_n, clr_n, clr_at, first_srst);
    check_eq("t2_first_srst", first_srst, 7);
    check_eq("t2_drain_timeout", dto[0], 1'b0);
    pulse_irq_clear();

    // Drain timeout on the DrainTimeout=4 unit.
    wr_req[0] = 1'b1; wr_req[1] = 1'b1; inflight[1] = 1'b1;
    run_seq(1, 0, 0, iso_n, srst_n, clr_n, clr_at, first_srst);
    check_eq("t3_first_srst", first_srst, 5);
    check_eq("t3_drain_timeout", dto[1], 1'b1);
    inflight[1] = 1'b0;
    pulse_irq_clear();

    // Write request raised during RESET of a read sequence.
    rst_cycles = 8'd3; settle_cycles = 8'd0;
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    run_seq(0, 0, 2, iso_n, srst_n, clr_n, clr_at, first_srst);
    check_eq("t4_clr_pulses", clr_n, 1);
    check_eq("t4_clr_at", clr_at, 5);
    check_eq("t4_cause", cause[0], 2'b11);
    pulse_irq_clear();

    // Zero reset and settle lengths: minimum latency, then irq_clear.
    rst_cycles = 8'd0; settle_cycles = 8'd0;
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    run_seq(0, 0, 0, iso_n, srst_n, clr_n, clr_at, first_srst);
    check_eq("t5_srst_cycles", srst_n, 1);
    check_eq("t5_clr_at", clr_at, 3);
    check_eq("t5_irq_before", irq[0], 1'b1);
    pulse_irq_clear();
    check_eq("t5_irq_after", irq[0], 1'b0);
    check_eq("t5_cause_after", cause[0], 2'b00);

    // Asynchronous reset during SETTLE.
    rst_cycles = 8'd2; settle_cycles = 8'd5;
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (m_phase[0] == P_SET) break;
    end
    check_eq("t6_in_settle", slv_rst[0] == 1'b0 && isolate[0] == 1'b1, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    check_all();
    check_eq("t6_isolate_rst", isolate[0], 1'b0);
    check_eq("t6_busy_rst", busy[0], 1'b0);
    for (int i = 0; i < 2; i++) begin rd_req[i] = 1'b0; wr_req[i] = 1'b0; end
    @(posedge clk);
    #1 rst_i = 1'b0;
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
    check_eq("t6_evt_zero", evt[0], 8'd0);
`endif
    rst_cycles = 8'd1; settle_cycles = 8'd0;
    rd_req[0] = 1'b1; rd_req[1] = 1'b1;
    run_seq(0, 0, 0, iso_n, srst_n, clr_n, clr_at, first_srst);
`ifdef GUARD_RESET_CTRL_EVT_CNT_EN
    check_eq("t6_evt_one", evt[0], 8'd1);
`endif
    check_eq("t6_clr_pulses", clr_n, 1);

    // Randomized traffic: guards raise requests, inflight and lengths vary.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 9) == 0) rd_req[i] = 1'b1;
        if ($urandom_range(0, 11) == 0) wr_req[i] = 1'b1;
        inflight[i] = ($urandom_range(0, 2) != 0);
      end
      rst_cycles    = 8'($urandom_range(0, 4));
      settle_cycles = 8'($urandom_range(0, 3));
      irq_clear     = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Quiesce so the run ends in IDLE.
    irq_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin rd_req[i] = 1'b0; wr_req[i] = 1'b0; inflight[i] = 1'b0; end
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (m_phase[0] == P_IDLE && m_phase[1] == P_IDLE) break;
    end
    check_eq("final_busy0", busy[0], 1'b0);
    check_eq("final_busy1", busy[1], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/guard_reset_ctrl.md
Name: guard_reset_ctrl

Overview:
- Recovery sequencer shared by the read and write guards of the AXI monitor.
- Takes their latched reset requests and isolates the guarded AXI port. It drains in-flight handshakes, pulses a reset to the guarded slave, waits a settle time, then issues a one-cycle reset_clear back to both guards.
- Sits between the guards, the AXI isolation logic and the slave's reset input.

Parameters:
- CntWidth, 8, width of the reset-hold and settle cycle counters and their config inputs.
- DrainTimeout, 64, maximum ISOLATE cycles spent waiting for inflight_i to fall; must be >= 1.
- EvtCntWidth, 8, width of the optional reset-event counter.

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous reset, active-high.
- rd_reset_req_i  in  1  level request from the read guard; held until cleared.
- wr_reset_req_i  in  1  level request from the write guard; held until cleared.
- inflight_i  in  1  1 while any AXI valid is pending without ready on the guarded port.
- rst_cycles_i  in  CntWidth  slave reset hold length; 0 is treated as 1.
- settle_cycles_i  in  CntWidth  post-reset wait; 0 means no wait.
- irq_clear_i  in  1  clears irq_o and cause_o.
- isolate_o  out  1  block new AR/AW acceptance and force-complete the port.
- slv_rst_o  out  1  active-high reset to the guarded slave.
- reset_clear_o  out  1  one-cycle pulse to both guards' reset_clear_i.
- busy_o  out  1  FSM not in IDLE.
- cause_o  out  2  sticky cause: bit0 = read, bit1 = write.
- drain_timeout_o  out  1  sticky: drain ended by timeout rather than by inflight_i falling.
- irq_o  out  1  sticky interrupt.
- evt_cnt_o  out  EvtCntWidth  reset events; present only with the macro.

Behaviour:
- Reset values: all outputs 0 and state IDLE.
- All outputs are registered, so every output follows the state register.
- States: IDLE, ISOLATE, RESET, SETTLE, CLEAR.
- IDLE:
  - req = rd_reset_req_i | wr_reset_req_i.
  - When req=1: go to ISOLATE next cycle.
  - On that transition: cause_o |= {wr,rd}; irq_o <= 1; load the counter with DrainTimeout-1.
- ISOLATE:
  - isolate_o=1.
  - If inflight_i=0: go to RESET.
  - Else if the counter is 0: go to RESET and set drain_timeout_o.
  - Else decrement the counter.
  - Worst case is exactly DrainTimeout cycles in ISOLATE.
  - On exit, load the counter with max(rst_cycles_i,1)-1.
- RESET:
  - isolate_o=1, slv_rst_o=1.
  - Stays max(rst_cycles_i,1) cycles.
  - rst_cycles_i is sampled only at entry; changes mid-sequence are ignored.
  - On exit: if settle_cycles_i==0 go to CLEAR, else go to SETTLE with the counter loaded to settle_cycles_i-1.
- SETTLE: isolate_o=1, slv_rst_o=0; stays settle_cycles_i cycles, then goes to CLEAR.
- CLEAR:
  - isolate_o=1, reset_clear_o=1 for exactly one cycle; next state IDLE.
  - The guards drop their requests on the same edge, so IDLE sees req=0 unless a guard re-raised it in that cycle. A re-raise starts a new sequence, with cause bits OR-ed.
- Requests arriving while not in IDLE:
  - OR-ed into cause_o.
  - No restart and no extra sequence; the single CLEAR clears both guards.
- Minimum latency from req to reset_clear_o: 1 (IDLE→ISOLATE) + 1 ISOLATE cycle + 1 RESET cycle + 1 CLEAR cycle.
  - Request rises at cycle 0 → reset_clear_o high at cycle 3, with inflight_i=0 and rst_cycles_i≤1.
- irq_clear_i:
  - Clears irq_o, cause_o and drain_timeout_o.
  - If it coincides with a set event (IDLE→ISOLATE transition, new cause bit, or timeout), the set wins.
  - It does not affect the FSM.
- busy_o = (state != IDLE).
- rst_i mid-sequence: immediately returns to IDLE with all outputs 0. slv_rst_o is therefore cut short, which is acceptable because the system reset also resets the slave.
- Counter arithmetic:
  - Counter is CntWidth bits.
  - DrainTimeout must fit in CntWidth, checked by an elaboration assertion.
  - No wrap-around: the counter never decrements below 0.

Optional Feature:
- Macro: GUARD_RESET_CTRL_EVT_CNT_EN.
- Defined:
  - evt_cnt_o increments by 1 on each IDLE→ISOLATE transition.
  - Saturates at all-ones.
  - Cleared only by rst_i.
- Undefined: the port is absent and there is no counter logic.

Decomposition:
- Package guard_reset_ctrl_pkg:
  - State enum guard_rst_state_e (IDLE, ISOLATE, RESET, SETTLE, CLEAR), 3-bit encoding.
  - Cause bit index constants CauseRd=0, CauseWr=1.
- One sub-module, guard_cycle_counter: loadable down-counter with a zero flag and saturation at 0, shared by the drain, reset and settle phases.

Test Plan:
- Single read request, inflight_i=0, rst_cycles_i=3, settle_cycles_i=2 → isolate_o high for 7 cycles; slv_rst_o high for exactly 3; reset_clear_o pulses once at cycle 7; cause_o=2'b01; irq_o=1.
- Drain wait: request with inflight_i held high for 5 cycles (DrainTimeout=64) → RESET entered in the cycle after inflight_i falls; drain_timeout_o=0.
- Drain timeout: inflight_i stuck high with DrainTimeout=4 → exactly 4 ISOLATE cycles, then RESET; drain_timeout_o=1.
- Write request raised during RESET of a read sequence → one sequence only; cause_o=2'b11; a single reset_clear_o pulse.
- rst_cycles_i=0, settle_cycles_i=0 → 1-cycle slv_rst_o, SETTLE skipped; irq_clear_i pulsed afterwards → irq_o=0, cause_o=0.
- rst_i asserted during SETTLE → all outputs 0 in the same cycle; with the macro defined, evt_cnt_o=0 after reset and increments to 1 on the next request.
